// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
// Reset/lock sequencer for the PLL primitive wrapper, clocked by the PLL
// reference clock. It pulses the PLL reset, qualifies LOCK through a 2-flop
// synchronizer and a stability window, and retries on lock timeout until a
// sticky failure is declared. Run-time divider changes arrive over a
// valid/ready handshake and are applied together with a fresh PLL reset.
//
// Ports
//   clkin                                  controller clock (PLL reference)
//   reset                                  synchronous, active-high
//   pll_lock                               PLL LOCK, asynchronous to clkin
//   cfg_valid, cfg_idsel/fbdsel/odsel      reconfiguration request
//   cfg_ready                              request can be accepted this cycle
//   pll_reset, pll_idsel/fbdsel/odsel      to the PLL primitive
//   locked, user_rst                       qualified lock and its inverse
//   fail                                   sticky failure flag
//   lock_lost                              one-cycle pulse on lock loss in RUN
module pll_lock_ctrl #(
    parameter int         RST_HOLD_CYC     = 16,
    parameter int         LOCK_TIMEOUT_CYC = 65535,
    parameter int         LOCK_STABLE_CYC  = 1024,
    parameter int         MAX_RETRY        = 3,
    parameter logic [5:0] DEF_IDSEL        = 6'd0,
    parameter logic [5:0] DEF_FBDSEL       = 6'd0,
    parameter logic [5:0] DEF_ODSEL        = 6'd0
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       cfg_valid,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       cfg_ready,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       locked,
    output logic       user_rst,
    output logic       fail,
    output logic       lock_lost
);

    // A parameter of 1 would give a zero-width counter; keep at least one bit.
    localparam int HOLD_W  = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;
    localparam int TMO_W   = (LOCK_TIMEOUT_CYC > 1) ? $clog2(LOCK_TIMEOUT_CYC) : 1;
    localparam int STB_W   = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [STB_W-1:0]   STB_LAST   = STB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_ASSERT_RST = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    logic               lock_meta_r, lock_sync_r;
    state_t             state_r, state_nxt_s;
    logic [HOLD_W-1:0]  hold_cnt_r, hold_cnt_nxt_s;
    logic [TMO_W-1:0]   tmo_cnt_r, tmo_cnt_nxt_s;
    logic [STB_W-1:0]   stb_cnt_r, stb_cnt_nxt_s;
    logic [RETRY_W-1:0] retry_cnt_r, retry_cnt_nxt_s;
    logic               apply_pend_r, apply_pend_nxt_s;
    logic [5:0]         pend_idsel_r, pend_fbdsel_r, pend_odsel_r;
    logic [5:0]         pend_idsel_nxt_s, pend_fbdsel_nxt_s, pend_odsel_nxt_s;
    logic [5:0]         idsel_r, fbdsel_r, odsel_r;
    logic [5:0]         idsel_nxt_s, fbdsel_nxt_s, odsel_nxt_s;
    logic               pll_reset_r, locked_r, user_rst_r, fail_r, lock_lost_r, cfg_ready_r;
    logic               pll_reset_nxt_s, locked_nxt_s, cfg_ready_nxt_s, fail_nxt_s, lock_lost_nxt_s;
    logic               accept_s, timeout_s, retry_last_s;

    assign accept_s     = cfg_valid & cfg_ready_r;
    assign timeout_s    = (tmo_cnt_r == TMO_LAST);
    assign retry_last_s = (retry_cnt_r == RETRY_LAST);

    // Two-flop synchronizer bringing the asynchronous LOCK into clkin.
    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Next-state, counter and output decode; outputs follow the next state.
    always_comb begin
        state_nxt_s       = state_r;
        hold_cnt_nxt_s    = hold_cnt_r;
        tmo_cnt_nxt_s     = tmo_cnt_r;
        stb_cnt_nxt_s     = stb_cnt_r;
        retry_cnt_nxt_s   = retry_cnt_r;
        apply_pend_nxt_s  = 1'b0;
        pend_idsel_nxt_s  = pend_idsel_r;
        pend_fbdsel_nxt_s = pend_fbdsel_r;
        pend_odsel_nxt_s  = pend_odsel_r;
        idsel_nxt_s       = idsel_r;
        fbdsel_nxt_s      = fbdsel_r;
        odsel_nxt_s       = odsel_r;
        fail_nxt_s        = fail_r;
        lock_lost_nxt_s   = 1'b0;

        if (apply_pend_r) begin
            // Second cycle of an accept: dividers move in the same cycle the
            // PLL enters reset, so they never change while the PLL runs.
            state_nxt_s     = ST_ASSERT_RST;
            hold_cnt_nxt_s  = {HOLD_W{1'b0}};
            retry_cnt_nxt_s = {RETRY_W{1'b0}};
            fail_nxt_s      = 1'b0;
            idsel_nxt_s     = pend_idsel_r;
            fbdsel_nxt_s    = pend_fbdsel_r;
            odsel_nxt_s     = pend_odsel_r;
        end else if (accept_s) begin
            // Accept outranks a simultaneous lock loss; no lock_lost pulse.
            apply_pend_nxt_s  = 1'b1;
            pend_idsel_nxt_s  = cfg_idsel;
            pend_fbdsel_nxt_s = cfg_fbdsel;
            pend_odsel_nxt_s  = cfg_odsel;
        end else begin
            case (state_r)
                ST_ASSERT_RST: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_nxt_s   = ST_WAIT_LOCK;
                        tmo_cnt_nxt_s = {TMO_W{1'b0}};
                        stb_cnt_nxt_s = {STB_W{1'b0}};
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                    if (timeout_s) begin
                        if (retry_last_s) begin
                            state_nxt_s     = ST_FAIL;
                            fail_nxt_s      = 1'b1;
                            retry_cnt_nxt_s = RETRY_MAX;
                        end else begin
                            state_nxt_s     = ST_ASSERT_RST;
                            hold_cnt_nxt_s  = {HOLD_W{1'b0}};
                            retry_cnt_nxt_s = retry_cnt_r + RETRY_W'(1);
                        end
                    end else if (lock_sync_r) begin
                        state_nxt_s   = ST_STABLE;
                        stb_cnt_nxt_s = {STB_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                    // A lock that completes its window on the timeout cycle still counts.
                    if (lock_sync_r && (stb_cnt_r == STB_LAST)) begin
                        state_nxt_s     = ST_RUN;
                        retry_cnt_nxt_s = {RETRY_W{1'b0}};
                    end else if (timeout_s) begin
                        if (retry_last_s) begin
                            state_nxt_s     = ST_FAIL;
                            fail_nxt_s      = 1'b1;
                            retry_cnt_nxt_s = RETRY_MAX;
                        end else begin
                            state_nxt_s     = ST_ASSERT_RST;
                            hold_cnt_nxt_s  = {HOLD_W{1'b0}};
                            retry_cnt_nxt_s = retry_cnt_r + RETRY_W'(1);
                        end
                    end else if (!lock_sync_r) begin
                        // Glitch: restart the window, keep the attempt timer.
                        state_nxt_s   = ST_WAIT_LOCK;
                        stb_cnt_nxt_s = {STB_W{1'b0}};
                    end else begin
                        stb_cnt_nxt_s = stb_cnt_r + STB_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_sync_r) begin
                        state_nxt_s     = ST_ASSERT_RST;
                        hold_cnt_nxt_s  = {HOLD_W{1'b0}};
                        retry_cnt_nxt_s = {RETRY_W{1'b0}};
                        lock_lost_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    state_nxt_s = ST_FAIL;
                end
                default: begin
                    state_nxt_s    = ST_ASSERT_RST;
                    hold_cnt_nxt_s = {HOLD_W{1'b0}};
                end
            endcase
        end

        pll_reset_nxt_s = (state_nxt_s == ST_ASSERT_RST) || (state_nxt_s == ST_FAIL);
        locked_nxt_s    = (state_nxt_s == ST_RUN);
        cfg_ready_nxt_s = ((state_nxt_s == ST_RUN) || (state_nxt_s == ST_FAIL)) && !apply_pend_nxt_s;
    end

    // State, counter, pending-config and registered-output update.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_r       <= ST_ASSERT_RST;
            hold_cnt_r    <= {HOLD_W{1'b0}};
            tmo_cnt_r     <= {TMO_W{1'b0}};
            stb_cnt_r     <= {STB_W{1'b0}};
            retry_cnt_r   <= {RETRY_W{1'b0}};
            apply_pend_r  <= 1'b0;
            pend_idsel_r  <= DEF_IDSEL;
            pend_fbdsel_r <= DEF_FBDSEL;
            pend_odsel_r  <= DEF_ODSEL;
            idsel_r       <= DEF_IDSEL;
            fbdsel_r      <= DEF_FBDSEL;
            odsel_r       <= DEF_ODSEL;
            pll_reset_r   <= 1'b1;
            locked_r      <= 1'b0;
            user_rst_r    <= 1'b1;
            fail_r        <= 1'b0;
            lock_lost_r   <= 1'b0;
            cfg_ready_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            hold_cnt_r    <= hold_cnt_nxt_s;
            tmo_cnt_r     <= tmo_cnt_nxt_s;
            stb_cnt_r     <= stb_cnt_nxt_s;
            retry_cnt_r   <= retry_cnt_nxt_s;
            apply_pend_r  <= apply_pend_nxt_s;
            pend_idsel_r  <= pend_idsel_nxt_s;
            pend_fbdsel_r <= pend_fbdsel_nxt_s;
            pend_odsel_r  <= pend_odsel_nxt_s;
            idsel_r       <= idsel_nxt_s;
            fbdsel_r      <= fbdsel_nxt_s;
            odsel_r       <= odsel_nxt_s;
            pll_reset_r   <= pll_reset_nxt_s;
            locked_r      <= locked_nxt_s;
            user_rst_r    <= ~locked_nxt_s;
            fail_r        <= fail_nxt_s;
            lock_lost_r   <= lock_lost_nxt_s;
            cfg_ready_r   <= cfg_ready_nxt_s;
        end
    end

    assign cfg_ready  = cfg_ready_r;
    assign pll_reset  = pll_reset_r;
    assign pll_idsel  = idsel_r;
    assign pll_fbdsel = fbdsel_r;
    assign pll_odsel  = odsel_r;
    assign locked     = locked_r;
    assign user_rst   = user_rst_r;
    assign fail       = fail_r;
    assign lock_lost  = lock_lost_r;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Testbench for pll_lock_ctrl. Randomized lock delays, glitch shapes and
// divider requests; expected event times come from arithmetic on the
// stimulus (hold length, sync latency, stability window, timeout) and the
// expected dividers from a small record of the last reset/accept.
module tb_pll_lock_ctrl;

    localparam int HOLD = 4;
    localparam int TMO  = 100;
    localparam int STB  = 8;
    localparam int MAXR = 2;
    localparam logic [5:0] D_ID = 6'd1;
    localparam logic [5:0] D_FB = 6'd2;
    localparam logic [5:0] D_OD = 6'd3;

    localparam int P_PLL_RESET = 0;
    localparam int P_LOCKED    = 1;
    localparam int P_FAIL      = 2;

    logic       clkin = 1'b0;
    logic       reset, pll_lock, cfg_valid;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
    logic       cfg_ready, pll_reset, locked, user_rst, fail, lock_lost;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    int rst_rise_cnt = 0;
    int lost_cnt = 0;
    logic prev_pr = 1'b1;
    logic [5:0] exp_id, exp_fb, exp_od;

    pll_lock_ctrl #(
        .RST_HOLD_CYC(HOLD), .LOCK_TIMEOUT_CYC(TMO), .LOCK_STABLE_CYC(STB),
        .MAX_RETRY(MAXR), .DEF_IDSEL(D_ID), .DEF_FBDSEL(D_FB), .DEF_ODSEL(D_OD)
    ) dut (
        .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .cfg_valid(cfg_valid),
        .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
        .cfg_ready(cfg_ready), .pll_reset(pll_reset), .pll_idsel(pll_idsel),
        .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel), .locked(locked),
        .user_rst(user_rst), .fail(fail), .lock_lost(lock_lost)
    );

    always #5 clkin = ~clkin;

    // Edge counter plus pll_reset rise and lock_lost pulse monitors.
    always @(posedge clkin) begin
        edge_cnt <= edge_cnt + 1;
        prev_pr  <= pll_reset;
        if (pll_reset && !prev_pr) rst_rise_cnt <= rst_rise_cnt + 1;
        if (lock_lost) lost_cnt <= lost_cnt + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            P_PLL_RESET: return pll_reset;
            P_LOCKED:    return locked;
            P_FAIL:      return fail;
            default:     return 1'b0;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clkin);
    endtask

    // Wait (bounded) until the probed output has the given value; -1 on expiry.
    task automatic wait_probe(input int sel, input logic val, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (probe(sel) == val) begin
                at = edge_cnt;
                break;
            end
            @(negedge clkin);
        end
    endtask

    task automatic check_sels(input string tag);
        check_eq({tag, " idsel"}, pll_idsel, exp_id);
        check_eq({tag, " fbdsel"}, pll_fbdsel, exp_fb);
        check_eq({tag, " odsel"}, pll_odsel, exp_od);
    endtask

    task automatic do_reset(input string tag, output int r);
        reset = 1'b1; cfg_valid = 1'b0; pll_lock = 1'b0;
        @(negedge clkin);
        reset = 1'b0;
        r = edge_cnt;
        exp_id = D_ID; exp_fb = D_FB; exp_od = D_OD;
        check_eq({tag, " rst pll_reset"}, pll_reset, 1);
        check_eq({tag, " rst locked"}, locked, 0);
        check_eq({tag, " rst user_rst"}, user_rst, 1);
        check_eq({tag, " rst fail"}, fail, 0);
        check_eq({tag, " rst lock_lost"}, lock_lost, 0);
        check_eq({tag, " rst cfg_ready"}, cfg_ready, 0);
        check_sels({tag, " rst"});
    endtask

    // PLL reset rose after edge 'rise'; raise LOCK d cycles after it falls.
    task automatic bring_up(input string tag, input int rise, input int d);
        int f, at, n;
        wait_probe(P_PLL_RESET, 1'b0, HOLD + 4, f);
        check_eq({tag, " hold"}, f - rise, HOLD);
        check_sels({tag, " at release"});
        step(d - 1);
        pll_lock = 1'b1;
        n = edge_cnt + 1;
        wait_probe(P_LOCKED, 1'b1, d + STB + 8, at);
        check_eq({tag, " lock latency"}, at - n, 2 + STB);
        check_eq({tag, " user_rst"}, user_rst, 0);
        check_eq({tag, " fail"}, fail, 0);
        check_eq({tag, " cfg_ready"}, cfg_ready, 1);
        check_eq({tag, " pll_reset"}, pll_reset, 0);
        check_sels({tag, " at lock"});
    endtask

    task automatic glitch_lock(input string tag, input int rise, input int d, input int h, input int l);
        int f, at, n2, base_r, base_l;
        wait_probe(P_PLL_RESET, 1'b0, HOLD + 4, f);
        check_eq({tag, " hold"}, f - rise, HOLD);
        base_r = rst_rise_cnt; base_l = lost_cnt;
        step(d - 1);
        pll_lock = 1'b1; step(h);
        pll_lock = 1'b0; step(l);
        pll_lock = 1'b1;
        n2 = edge_cnt + 1;
        wait_probe(P_LOCKED, 1'b1, STB + 10, at);
        check_eq({tag, " relock latency"}, at - n2, 2 + STB);
        step(3);
        check_eq({tag, " no extra reset"}, rst_rise_cnt, base_r);
        check_eq({tag, " no lock_lost"}, lost_cnt, base_l);
    endtask

    // Handshake in RUN or FAIL; returns the edge at which pll_reset rises.
    task automatic do_accept(input string tag, input logic [5:0] id, input logic [5:0] fb,
                             input logic [5:0] od, output int k1);
        check_eq({tag, " ready"}, cfg_ready, 1);
        cfg_idsel = id; cfg_fbdsel = fb; cfg_odsel = od; cfg_valid = 1'b1;
        step(1);
        check_eq({tag, " accepted 1cyc"}, cfg_ready, 0);
        check_eq({tag, " no lost@k"}, lock_lost, 0);
        check_sels({tag, " old@k"});
        cfg_valid = 1'b0;
        cfg_idsel = ~id; cfg_fbdsel = ~fb; cfg_odsel = ~od;
        exp_id = id; exp_fb = fb; exp_od = od;
        pll_lock = 1'b0;
        step(1);
        k1 = edge_cnt;
        check_eq({tag, " pll_reset@k+1"}, pll_reset, 1);
        check_eq({tag, " locked@k+1"}, locked, 0);
        check_eq({tag, " user_rst@k+1"}, user_rst, 1);
        check_eq({tag, " fail@k+1"}, fail, 0);
        check_eq({tag, " no lost@k+1"}, lock_lost, 0);
        check_sels({tag, " new@k+1"});
    endtask

    task automatic lock_drop(input string tag, output int rise);
        pll_lock = 1'b0;
        step(1);
        check_eq({tag, " lost m"}, lock_lost, 0);
        step(1);
        check_eq({tag, " lost m+1"}, lock_lost, 0);
        check_eq({tag, " locked m+1"}, locked, 1);
        step(1);
        rise = edge_cnt;
        check_eq({tag, " lost m+2"}, lock_lost, 1);
        check_eq({tag, " locked m+2"}, locked, 0);
        check_eq({tag, " user_rst m+2"}, user_rst, 1);
        check_eq({tag, " pll_reset m+2"}, pll_reset, 1);
        step(1);
        check_eq({tag, " lost m+3"}, lock_lost, 0);
    endtask

    // LOCK held low: MAXR attempts, each HOLD high then TMO low, then FAIL.
    task automatic timeout_run(input string tag, input int rise);
        int f, t;
        for (int a = 1; a <= MAXR; a++) begin
            wait_probe(P_PLL_RESET, 1'b0, HOLD + 4, f);
            check_eq({tag, " hold"}, f - rise, HOLD);
            wait_probe(P_PLL_RESET, 1'b1, TMO + 5, t);
            check_eq({tag, " timeout"}, t - f, TMO);
            check_eq({tag, " fail flag"}, fail, (a == MAXR) ? 1 : 0);
            rise = t;
        end
        check_eq({tag, " cfg_ready"}, cfg_ready, 1);
        check_eq({tag, " locked"}, locked, 0);
        step(30);
        check_eq({tag, " stuck pll_reset"}, pll_reset, 1);
        check_eq({tag, " sticky fail"}, fail, 1);
    endtask

    initial begin
        int r, k, f, t;
        reset = 1'b1; pll_lock = 1'b0; cfg_valid = 1'b0;
        cfg_idsel = 6'd0; cfg_fbdsel = 6'd0; cfg_odsel = 6'd0;
        exp_id = D_ID; exp_fb = D_FB; exp_od = D_OD;
        step(2);

        do_reset("s1", r);
        bring_up("s1 normal", r, 10);
        for (int i = 0; i < 3; i++) begin
            do_reset("s1r", r);
            bring_up("s1 rand", r, $urandom_range(1, 60));
        end

        do_reset("s2", r);
        glitch_lock("s2 glitch", r, 10, 5, 1);
        for (int i = 0; i < 2; i++) begin
            do_reset("s2r", r);
            glitch_lock("s2 rand", r, $urandom_range(1, 40), $urandom_range(1, 7), $urandom_range(1, 3));
        end

        lock_drop("s5 drop", r);
        bring_up("s5 relock", r, $urandom_range(1, 30));

        do_accept("s4 cfg", 6'd15, 6'd3, 6'd8, k);
        bring_up("s4 relock", k, 10);
        for (int i = 0; i < 2; i++) begin
            do_accept("s4 rand", 6'($urandom), 6'($urandom), 6'($urandom), k);
            bring_up("s4 rand relock", k, $urandom_range(1, 40));
        end

        // Lock falls so that the accept lands on the edge lock_s is seen low.
        pll_lock = 1'b0;
        step(2);
        do_accept("s5 accept+loss", 6'($urandom), 6'($urandom), 6'($urandom), k);
        bring_up("s5 accept relock", k, $urandom_range(1, 30));

        do_reset("s3", r);
        timeout_run("s3 timeout", r);
        do_accept("s3 from fail", 6'($urandom), 6'($urandom), 6'($urandom), k);
        bring_up("s3 recover", k, $urandom_range(1, 40));

        do_accept("s6 cfg", 6'd15, 6'($urandom), 6'($urandom), k);
        wait_probe(P_PLL_RESET, 1'b0, HOLD + 4, f);
        check_eq("s6 hold", f - k, HOLD);
        wait_probe(P_PLL_RESET, 1'b1, TMO + 5, t);
        check_eq("s6 first timeout", t - f, TMO);
        check_eq("s6 no fail yet", fail, 0);
        wait_probe(P_PLL_RESET, 1'b0, HOLD + 4, f);
        step($urandom_range(5, 50));
        do_reset("s6 mid-wait", r);
        timeout_run("s6 retry cleared", r);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

endmodule
